// File: rtl/spi_regbank_ctrl.sv
// Config register bank shared between the SPI slave (never stalls) and an
// on-chip core port (valid/ready request, single-cycle response).
module spi_regbank_ctrl #(
   parameter int unsigned          ADDR_W  = 3,
   parameter int unsigned          REG_W   = 8,
   parameter logic [REG_W-1:0]     RST_VAL = '0
) (
   input  logic                           clk,
   input  logic                           nrst,
   input  logic [ADDR_W-1:0]              spi_addr,
   input  logic [REG_W-1:0]               spi_wdata,
   input  logic                           spi_wvld,
   output logic [REG_W-1:0]               spi_rdata,
   input  logic [5:0]                     spi_fastcmd,
   input  logic                           spi_fastcmd_vld,
   output logic [7:0]                     spi_status,
   input  logic                           core_req_vld,
   output logic                           core_req_rdy,
   input  logic                           core_req_we,
   input  logic [ADDR_W-1:0]              core_req_addr,
   input  logic [REG_W-1:0]               core_req_wdata,
   output logic                           core_rsp_vld,
   output logic [REG_W-1:0]               core_rsp_rdata,
   output logic [REG_W*(2**ADDR_W)-1:0]   regs_q
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   typedef enum logic {S_IDLE = 1'b0, S_RSP = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [REG_W-1:0]  regs [DEPTH];
   logic              locked;
   logic              drop_flg;
   logic              stall_flg;
   logic [3:0]        wr_cnt;

   logic fc_clear, fc_lock, fc_unlock, fc_clrflg;
   logic spi_wr_ok, spi_drop, core_acc, core_wr, core_stall;

   // Fast command decode; unknown codes decode to nothing.
   assign fc_clear  = spi_fastcmd_vld && (spi_fastcmd == 6'h01);
   assign fc_lock   = spi_fastcmd_vld && (spi_fastcmd == 6'h02);
   assign fc_unlock = spi_fastcmd_vld && (spi_fastcmd == 6'h03);
   assign fc_clrflg = spi_fastcmd_vld && (spi_fastcmd == 6'h04);

   assign spi_wr_ok  = spi_wvld && !locked && !fc_clear;
   assign spi_drop   = spi_wvld && locked;
   assign core_acc   = core_req_vld && core_req_rdy;
   assign core_wr    = core_acc && core_req_we;
   assign core_stall = core_req_vld && (state_q == S_IDLE) && !core_req_rdy;

   // Core FSM state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Core FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (core_acc) state_d = S_RSP;
         S_RSP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Core FSM outputs; rdy yields to any SPI strobe and is held low in reset
   always_comb begin
      core_req_rdy = 1'b0;
      core_rsp_vld = 1'b0;
      case (state_q)
         S_IDLE:  core_req_rdy = nrst && !spi_wvld && !spi_fastcmd_vld;
         S_RSP:   core_rsp_vld = 1'b1;
         default: ;
      endcase
   end

   // Register bank: clear > SPI write > core write
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
      end else if (fc_clear) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
      end else if (spi_wr_ok) begin
         regs[spi_addr] <= spi_wdata;
      end else if (core_wr) begin
         regs[core_req_addr] <= core_req_wdata;
      end
   end

   // Lock, sticky flags (set beats clear) and SPI write counter
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         locked    <= 1'b0;
         drop_flg  <= 1'b0;
         stall_flg <= 1'b0;
         wr_cnt    <= 4'd0;
      end else begin
         if (fc_lock)        locked <= 1'b1;
         else if (fc_unlock) locked <= 1'b0;
         if (spi_drop)       drop_flg <= 1'b1;
         else if (fc_clrflg) drop_flg <= 1'b0;
         if (core_stall)     stall_flg <= 1'b1;
         else if (fc_clrflg) stall_flg <= 1'b0;
         if (spi_wr_ok)      wr_cnt <= wr_cnt + 4'(1);
      end
   end

   // Core response data captured on accept (pre-edge register value)
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)         core_rsp_rdata <= '0;
      else if (core_acc) core_rsp_rdata <= core_req_we ? '0 : regs[core_req_addr];
   end

   assign spi_rdata  = regs[spi_addr];
   assign spi_status = {locked, drop_flg, stall_flg, (state_q == S_RSP), wr_cnt};

   always_comb begin
      regs_q = '0;
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i*REG_W +: REG_W] = regs[i];
   end

endmodule
